reg8_rr_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer that shares one W-bit asynchronously-reset holding register among N requesters.
- Each requester raises req with its data. The block grants one requester at a time and loads that requester's data into the register.
- The block acknowledges the write and rotates priority, so no requester starves.
- Sits in front of the 8-bit data register; downstream logic reads q.

---
 rtl/reg8_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_reg8_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg8_rr_arbiter.sv
// Round-robin arbiter that shares one W-bit holding register among N requesters.
// A request is granted for one cycle. If it is still present at the next edge, its data is loaded.
module reg8_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [IW-1:0]  owner,
  output logic           busy,
  output logic [W-1:0]   q,
  output logic [15:0]    wr_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_ack;
  logic [IW-1:0] r_owner;
  logic          r_busy;
  logic [W-1:0]  r_q;
  logic [15:0]   r_wr_cnt;

  state_t        w_nxt_state;
  logic [IW-1:0] w_nxt_ptr;
  logic [N-1:0]  w_nxt_gnt;
  logic [N-1:0]  w_nxt_ack;
  logic [IW-1:0] w_nxt_owner;
  logic          w_nxt_busy;
  logic [W-1:0]  w_nxt_q;
  logic [15:0]   w_nxt_wr_cnt;

  logic          w_sel_valid;
  logic [IW-1:0] w_sel_idx;

  // Search starts at r_ptr and wraps. The first hit wins, so r_ptr has top priority.
  always_comb begin : sel_search
    int j;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_sel_valid && req[j]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IW'(j);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case statement, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_ptr    = r_ptr;
    w_nxt_gnt    = '0;
    w_nxt_ack    = '0;
    w_nxt_owner  = r_owner;
    w_nxt_busy   = 1'b0;
    w_nxt_q      = r_q;
    w_nxt_wr_cnt = r_wr_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          w_nxt_gnt[w_sel_idx] = 1'b1;
          w_nxt_owner          = w_sel_idx;
          w_nxt_busy           = 1'b1;
          w_nxt_state          = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn request returns to IDLE without touching r_ptr, so the same order is retried.
        if (req[r_owner]) begin
          w_nxt_q              = data_in[int'(r_owner)*W +: W];
          w_nxt_ack[r_owner]   = 1'b1;
          w_nxt_ptr            = (r_owner == IW'(N-1)) ? '0 : r_owner + IW'(1);
          w_nxt_wr_cnt         = r_wr_cnt + 16'd1;
        end
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_q      <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_ptr    <= w_nxt_ptr;
      r_gnt    <= w_nxt_gnt;
      r_ack    <= w_nxt_ack;
      r_owner  <= w_nxt_owner;
      r_busy   <= w_nxt_busy;
      r_q      <= w_nxt_q;
      r_wr_cnt <= w_nxt_wr_cnt;
    end
  end

  assign gnt    = r_gnt;
  assign ack    = r_ack;
  assign owner  = r_owner;
  assign busy   = r_busy;
  assign q      = r_q;
  assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_reg8_rr_arbiter.sv
// Self-checking bench for reg8_rr_arbiter.
// Directed scenarios are followed by randomized traffic checked against a rotating-priority model.
module tb_reg8_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [IW-1:0]  owner;
  logic           busy;
  logic [W-1:0]   q;
  logic [15:0]    wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  reg8_rr_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .gnt(gnt), .ack(ack), .owner(owner), .busy(busy), .q(q), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge, and new inputs are driven at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    set_data(0, 8'hEE);
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({q, gnt, ack, wr_cnt, busy, owner} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: q=%h gnt=%b ack=%b wr_cnt=%h busy=%b owner=%0d, all must be 0",
               q, gnt, ack, wr_cnt, busy, owner);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_grant: gnt=%b busy=%b, need gnt=0001 busy=1", gnt, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async_drop: gnt=%b busy=%b, need gnt=0000 busy=0", gnt, busy);
    end
    tick();
    n_checks++;
    if (q !== 8'h00 || ack !== 4'b0000 || wr_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_no_load: q=%h ack=%b wr_cnt=%0d, need q=00 ack=0000 wr_cnt=0", q, ack, wr_cnt);
    end
    req = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_data(2, 8'hAA);
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || owner !== 2'd2 || ack !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_grant: gnt=%b busy=%b owner=%0d ack=%b, need 0100/1/2/0000", gnt, busy, owner, ack);
    end
    tick();
    n_checks++;
    if (q !== 8'hAA || ack !== 4'b0100 || gnt !== 4'b0000 || wr_cnt !== 16'd1 || owner !== 2'd2) begin
      n_errors++;
      $display("FAIL single_write: q=%h ack=%b gnt=%b wr_cnt=%0d owner=%0d, need AA/0100/0000/1/2",
               q, ack, gnt, wr_cnt, owner);
    end
    req = '0;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || q !== 8'hAA) begin
      n_errors++;
      $display("FAIL single_ack_pulse: ack=%b q=%h, need ack=0000 q=AA", ack, q);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] vals [N] = '{8'h10, 8'h21, 8'h32, 8'h43};
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, vals[i]);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = N'(1) << (g % N);
      tick();
      n_checks++;
      if (gnt !== e || owner !== IW'(g % N)) begin
        n_errors++;
        $display("FAIL rr_grant_%0d: gnt=%b owner=%0d, need gnt=%b owner=%0d", g, gnt, owner, e, g % N);
      end
      tick();
      n_checks++;
      if (ack !== e || q !== vals[g % N] || wr_cnt !== 16'(g + 1)) begin
        n_errors++;
        $display("FAIL rr_write_%0d: ack=%b q=%h wr_cnt=%0d, need ack=%b q=%h wr_cnt=%0d",
                 g, ack, q, wr_cnt, e, vals[g % N], g + 1);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_withdrawal();
    do_reset();
    set_data(1, 8'h77);
    set_data(0, 8'h5C);
    req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL wd_grant: gnt=%b, need 0010", gnt);
    end
    req = '0;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || ack !== 4'b0000 || q !== 8'h00 || wr_cnt !== 16'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wd_no_write: gnt=%b ack=%b q=%h wr_cnt=%0d busy=%b, need 0000/0000/00/0/0",
               gnt, ack, q, wr_cnt, busy);
    end
    req = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL wd_ptr_kept: gnt=%b, need 0001", gnt);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0001 || q !== 8'h5C || wr_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL wd_then_write: ack=%b q=%h wr_cnt=%0d, need 0001/5C/1", ack, q, wr_cnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap_fairness();
    do_reset();
    set_data(2, 8'hA2);
    set_data(3, 8'hB3);
    set_data(0, 8'hC0);
    req = 4'b0100;
    tick();
    tick();
    req = 4'b1001;
    tick();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_errors++;
      $display("FAIL wrap_first: gnt=%b, need 1000", gnt);
    end
    tick();
    n_checks++;
    if (ack !== 4'b1000 || q !== 8'hB3) begin
      n_errors++;
      $display("FAIL wrap_write3: ack=%b q=%h, need 1000/B3", ack, q);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      n_errors++;
      $display("FAIL wrap_ptr0: gnt=%b owner=%0d, need 0001/0", gnt, owner);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0001 || q !== 8'hC0 || wr_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL wrap_write0: ack=%b q=%h wr_cnt=%0d, need 0001/C0/3", ack, q, wr_cnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.r_wr_cnt = 16'hFFFE;
    #1 release dut.r_wr_cnt;
    #1;
    n_checks++;
    if (wr_cnt !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL cnt_preload: wr_cnt=%h, need FFFE", wr_cnt);
    end
    set_data(1, 8'h11);
    req = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (wr_cnt !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL cnt_ffff: wr_cnt=%h, need FFFF", wr_cnt);
    end
    tick();
    tick();
    n_checks++;
    if (wr_cnt !== 16'h0000 || ack !== 4'b0010) begin
      n_errors++;
      $display("FAIL cnt_wrap: wr_cnt=%h ack=%b, need 0000/0010", wr_cnt, ack);
    end
    req = '0;
    tick();
  endtask

  // The model keeps the next-priority index as an integer.
  // Each grant searches that index onward modulo N.
  task automatic test_random();
    int           m_ptr   = 0;
    int           m_owner = 0;
    int           m_cnt   = 0;
    bit           m_busy  = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_ack;
    bit           prev_ack = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) set_data(i, W'($urandom));
      e_gnt = '0;
      e_ack = '0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (req[c]) begin
            e_gnt[c] = 1'b1;
            m_owner  = c;
            m_busy   = 1'b1;
            break;
          end
        end
      end else begin
        if (req[m_owner]) begin
          m_q            = data_in[m_owner*W +: W];
          e_ack[m_owner] = 1'b1;
          m_ptr          = (m_owner + 1) % N;
          m_cnt          = (m_cnt + 1) % 65536;
        end
        m_busy = 1'b0;
      end
      tick();
      n_checks++;
      if (gnt !== e_gnt || ack !== e_ack || busy !== m_busy || owner !== IW'(m_owner) ||
          q !== m_q || wr_cnt !== 16'(m_cnt)) begin
        n_errors++;
        $display("FAIL rand_cycle_%0d: gnt=%b ack=%b busy=%b owner=%0d q=%h cnt=%0d, need %b %b %b %0d %h %0d",
                 cyc, gnt, ack, busy, owner, q, wr_cnt, e_gnt, e_ack, m_busy, m_owner, m_q, m_cnt);
      end
      n_checks++;
      if (!$onehot0(gnt) || (gnt & ack) != '0 || (prev_ack && ack != '0)) begin
        n_errors++;
        $display("FAIL rand_invariant_%0d: gnt=%b ack=%b prev_ack=%b", cyc, gnt, ack, prev_ack);
      end
      prev_ack = (ack != '0);
    end
    req = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdrawal();
    test_wrap_fairness();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
